// File: rtl/dino_pkg.sv
// Shared types and screen/sprite geometry for the dino obstacle controller.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned GROUND_Y = 151;
  localparam int unsigned DINO_X   = 40;
  localparam int unsigned DINO_W   = 16;
  localparam int unsigned OBST_W   = 8;
  localparam int unsigned OBST_H   = 20;

  localparam int unsigned OBSTX_W  = 9;
  localparam int unsigned SCORE_W  = 10;

endpackage

// File: rtl/dino_tick_gen.sv
// Frame tick divider: counts clk cycles while enabled, pulses tick for one
// cycle every DIV cycles. Synchronous clear forces the count back to 0.
module dino_tick_gen #(
  parameter int unsigned DIV = 200000
) (
  input  logic clk,
  input  logic nRst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  // Cycle counter, wraps to 0 on the tick cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dino_obstacle_ctrl.sv
// Obstacle scroller, collision detector, score keeper and game FSM for the
// dino game. Optional macro SPEEDUP_EN: obstacle step grows by 1 every
// 8 points, capped at 2*SPEED.
module dino_obstacle_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned TICK_DIV = 200000,
  parameter int unsigned SPEED    = 2
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                button,
  input  logic [7:0]          dinoY,
  output logic [OBSTX_W-1:0]  obstX,
  output logic [SCORE_W-1:0]  score,
  output logic [1:0]          state,
  output logic                game_over,
  output logic                hit
);

  localparam logic [OBSTX_W-1:0] X_START   = OBSTX_W'(SCREEN_W - 1);
  localparam logic [OBSTX_W-1:0] STEP_BASE = OBSTX_W'(SPEED);
  localparam logic [9:0]         DINO_L    = 10'(DINO_X);
  localparam logic [9:0]         DINO_R    = 10'(DINO_X + DINO_W - 1);
  localparam logic [9:0]         OBST_EXT  = 10'(OBST_W - 1);
  localparam logic [8:0]         Y_LIMIT   = 9'(GROUND_Y + OBST_H);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t          state_q, state_d;
  logic [OBSTX_W-1:0]   obstx_q, obstx_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 button_q;
  logic                 rise;
  logic                 tick;
  logic                 collide;
  logic [OBSTX_W-1:0]   step;

`ifdef SPEEDUP_EN
  localparam logic [OBSTX_W-1:0] STEP_MAX = OBSTX_W'(2 * SPEED);
  logic [OBSTX_W-1:0]   step_q, step_d;
  assign step = step_q;
`else
  assign step = STEP_BASE;
`endif

  assign rise = button & ~button_q;

  // Overlap at 10 bits so obstX+OBST_W-1 cannot wrap; height at 9 bits.
  assign collide = ({1'b0, obstx_q} <= DINO_R) &&
                   (({1'b0, obstx_q} + OBST_EXT) >= DINO_L) &&
                   ({1'b0, dinoY} < Y_LIMIT);

  dino_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .nRst (nRst),
    .en   (state_q == RUN),
    .clr  (state_q != RUN),
    .tick (tick)
  );

  // Next-state, obstacle motion, collision and scoring.
  always_comb begin
    state_d = state_q;
    obstx_d = obstx_q;
    score_d = score_q;
    hit_d   = 1'b0;
`ifdef SPEEDUP_EN
    step_d  = step_q;
`endif
    case (state_q)
      IDLE: begin
        obstx_d = X_START;
        score_d = '0;
        if (rise) begin
          state_d = RUN;
`ifdef SPEEDUP_EN
          step_d  = STEP_BASE;
`endif
        end
      end
      RUN: begin
        if (tick) begin
          if (collide) begin
            state_d = OVER;
            hit_d   = 1'b1;
          end else if (obstx_q >= step) begin
            obstx_d = obstx_q - step;
          end else begin
            obstx_d = X_START;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_W'(1);
`ifdef SPEEDUP_EN
              if ((score_d[2:0] == 3'd0) && (step_q < STEP_MAX))
                step_d = step_q + OBSTX_W'(1);
`endif
            end
          end
        end
      end
      OVER: begin
        if (rise) begin
          state_d = RUN;
          obstx_d = X_START;
          score_d = '0;
`ifdef SPEEDUP_EN
          step_d  = STEP_BASE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      obstx_q  <= X_START;
      score_q  <= '0;
      hit_q    <= 1'b0;
      button_q <= 1'b0;
`ifdef SPEEDUP_EN
      step_q   <= STEP_BASE;
`endif
    end else begin
      state_q  <= state_d;
      obstx_q  <= obstx_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      button_q <= button;
`ifdef SPEEDUP_EN
      step_q   <= step_d;
`endif
    end
  end

  assign obstX     = obstx_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == OVER);
  assign hit       = hit_q;

endmodule

// File: tb/tb_dino_obstacle_ctrl.sv
// Scoreboard bench for dino_obstacle_ctrl: the driver advances a behavioural
// game model each cycle and queues the expected outputs; the monitor pops and
// compares after every clock edge.
module tb_dino_obstacle_ctrl;

  localparam int TICK  = 4;
  localparam int SPD   = 2;
  localparam int X0    = 319;

  logic       clk;
  logic       nRst;
  logic       button;
  logic [7:0] dinoY;
  logic [8:0] obstX;
  logic [9:0] score;
  logic [1:0] state;
  logic       game_over;
  logic       hit;

  dino_obstacle_ctrl #(
    .TICK_DIV (TICK)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .button    (button),
    .dinoY     (dinoY),
    .obstX     (obstX),
    .score     (score),
    .state     (state),
    .game_over (game_over),
    .hit       (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int x;
    int sc;
    int ht;
    int go;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model of the game: plain integers, phase = cycles spent running since the
  // last frame tick.
  int m_st, m_x, m_sc, m_hit, m_ph, m_pb, m_step;

  function automatic void model_reset();
    m_st = 0; m_x = X0; m_sc = 0; m_hit = 0; m_ph = 0; m_pb = 0; m_step = SPD;
  endfunction

  function automatic void model_step(input int b, input int dy);
    int rise;
    rise  = (b != 0 && m_pb == 0) ? 1 : 0;
    m_pb  = b;
    m_hit = 0;
    if (m_st == 0) begin
      m_x = X0; m_sc = 0;
      if (rise != 0) begin m_st = 1; m_ph = 0; m_step = SPD; end
    end else if (m_st == 1) begin
      m_ph = m_ph + 1;
      if (m_ph == TICK) begin
        m_ph = 0;
        if (m_x <= 40 + 16 - 1 && m_x + 8 - 1 >= 40 && dy < 151 + 20) begin
          m_st = 2; m_hit = 1;
        end else if (m_x >= m_step) begin
          m_x = m_x - m_step;
        end else begin
          m_x = X0;
          if (m_sc < 1023) begin
            m_sc = m_sc + 1;
`ifdef SPEEDUP_EN
            if (m_sc % 8 == 0 && m_step < 2 * SPD) m_step = m_step + 1;
`endif
          end
        end
      end
    end else begin
      if (rise != 0) begin m_st = 1; m_x = X0; m_sc = 0; m_ph = 0; m_step = SPD; end
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.st = m_st; e.x = m_x; e.sc = m_sc; e.ht = m_hit; e.go = (m_st == 2) ? 1 : 0;
    return e;
  endfunction

  // One cycle of stimulus: inputs change on the falling edge and the
  // expected post-edge outputs are queued for the monitor.
  task automatic drive(input logic b, input logic [7:0] dy);
    @(negedge clk);
    nRst   = 1'b1;
    button = b;
    dinoY  = dy;
    model_step(int'(b), int'(dy));
    q.push_back(snap());
  endtask

  task automatic hold_reset();
    @(negedge clk);
    nRst   = 1'b0;
    button = 1'b0;
    model_reset();
    q.push_back(snap());
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compares DUT outputs after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (int'(state) != e.st || int'(obstX) != e.x || int'(score) != e.sc ||
            int'(hit) != e.ht || int'(game_over) != e.go) begin
          errors++;
          $display("FAIL cycle %0d: got st=%0d x=%0d sc=%0d hit=%0d go=%0d expected st=%0d x=%0d sc=%0d hit=%0d go=%0d",
                   cyc, state, obstX, score, hit, game_over, e.st, e.x, e.sc, e.ht, e.go);
        end
      end
    end
  end

  initial begin
    int n;
    nRst   = 1'b0;
    button = 1'b0;
    dinoY  = 8'd151;
    model_reset();

    // Reset and idle: nothing moves.
    repeat (3) hold_reset();
    repeat (20) drive(1'b0, 8'd151);
    chk("idle_state", int'(state), 0);
    chk("idle_obstX", int'(obstX), 319);

    // Start; first tick 4 cycles after entering RUN.
    drive(1'b1, 8'd151);
    drive(1'b0, 8'd151);
    chk("start_state", int'(state), 1);
    repeat (4) drive(1'b0, 8'd151);
    chk("first_tick_x", int'(obstX), 317);
    repeat (4) drive(1'b0, 8'd151);
    chk("second_tick_x", int'(obstX), 315);

    // Grounded dino: run into the obstacle.
    n = 0;
    while (m_st != 2 && n < 1000) begin drive(1'b0, 8'd151); n++; end
    chk("collide_reached", (m_st == 2) ? 1 : 0, 1);
    drive(1'b0, 8'd151);
    chk("over_hit", int'(hit), 1);
    chk("over_x", int'(obstX), 55);
    chk("over_go", int'(game_over), 1);
    drive(1'b0, 8'd151);
    chk("hit_one_cycle", int'(hit), 0);
    repeat (10) drive(1'b0, 8'd151);
    chk("over_hold_x", int'(obstX), 55);

    // Restart from OVER, airborne dino: obstacle wraps and scores.
    drive(1'b1, 8'd200);
    drive(1'b0, 8'd200);
    chk("restart_state", int'(state), 1);
    chk("restart_x", int'(obstX), 319);
    chk("restart_score", int'(score), 0);
    repeat (4) drive(1'b0, 8'd200);
    chk("restart_tick_x", int'(obstX), 317);
    n = 0;
    while (m_sc != 1 && n < 2000) begin drive(1'b0, 8'd200); n++; end
    chk("wrap_reached", m_sc, 1);
    drive(1'b0, 8'd200);
    chk("wrap_x", int'(obstX), 319);
    chk("wrap_score", int'(score), 1);

    // Mid-run asynchronous reset at obstX=201.
    n = 0;
    while (m_x != 201 && n < 2000) begin drive(1'b0, 8'd200); n++; end
    chk("x201_reached", m_x, 201);
    drive(1'b0, 8'd200);
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_x", int'(obstX), 319);
    chk("arst_score", int'(score), 0);
    chk("arst_go", int'(game_over), 0);
    model_reset();
    q.push_back(snap());
    repeat (2) hold_reset();
    repeat (12) drive(1'b0, 8'd200);
    chk("post_reset_idle", int'(state), 0);

    // Randomised play: button pulses, dino hopping between ground and air.
    for (int i = 0; i < 4000; i++) begin
      logic       b;
      logic [7:0] dy;
      b  = ($urandom_range(0, 39) == 0);
      dy = ($urandom_range(0, 3) == 0) ? 8'(151 + $urandom_range(0, 25))
                                       : 8'(172 + $urandom_range(0, 60));
      drive(b, dy);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
